// File: rtl/distram_write_arbiter.sv
// Write-port owner for a dual-port distributed RAM: clear sweep after reset/flush, round-robin
// arbitration of two write requesters, masked combinational read port. Option: DISTRAM_WRITE_BYPASS_EN.

module distram_write_arbiter_ram #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [WIDTH-1:0]      dina,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [WIDTH-1:0]      doutb
);
    // No reset: contents are defined only by the owner's clear sweep.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wea) begin
            mem[addra] <= dina;
        end
    end

    assign doutb = mem[addrb];
endmodule

module distram_write_arbiter #(
    parameter int unsigned       WIDTH      = 32,
    parameter int unsigned       DEPTH      = 32,
    parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    output logic                          init_done,
    input  logic                          req0_valid,
    input  logic [$clog2(DEPTH)-1:0]      req0_addr,
    input  logic [WIDTH-1:0]              req0_data,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [$clog2(DEPTH)-1:0]      req1_addr,
    input  logic [WIDTH-1:0]              req1_data,
    output logic                          req1_ready,
    input  logic [$clog2(DEPTH)-1:0]      rd_addr,
    output logic [WIDTH-1:0]              rd_data
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
    logic                  last_grant, last_grant_nxt;

    logic                  grant0, grant1;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [WIDTH-1:0]      dina;
    logic [WIDTH-1:0]      ram_doutb;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        clr_cnt_nxt    = clr_cnt;
        last_grant_nxt = last_grant;
        grant0         = 1'b0;
        grant1         = 1'b0;
        wea            = 1'b0;
        addra          = '0;
        dina           = INIT_VALUE;

        case (state)
            CLEAR: begin
                wea   = 1'b1;
                addra = clr_cnt;
                dina  = INIT_VALUE;
                if (flush) begin
                    clr_cnt_nxt = '0;
                end else if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    clr_cnt_nxt = '0;
                    state_nxt   = RUN;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
                end
            end
            RUN: begin
                // On a tie the requester that did not win last time is granted.
                grant0 = req0_valid && (!req1_valid || last_grant);
                grant1 = req1_valid && (!req0_valid || !last_grant);
                if (grant0) begin
                    wea            = 1'b1;
                    addra          = req0_addr;
                    dina           = req0_data;
                    last_grant_nxt = 1'b0;
                end else if (grant1) begin
                    wea            = 1'b1;
                    addra          = req1_addr;
                    dina           = req1_data;
                    last_grant_nxt = 1'b1;
                end
                if (flush) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    assign init_done  = (state == RUN);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    distram_write_arbiter_ram #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .addrb (rd_addr),
        .doutb (ram_doutb)
    );

    always_comb begin
        rd_data = ram_doutb;
        if (state != RUN) begin
            rd_data = INIT_VALUE;
        end
`ifdef DISTRAM_WRITE_BYPASS_EN
        else if (wea && (rd_addr == addra)) begin
            rd_data = dina;
        end
`endif
    end
endmodule

// File: tb/tb_distram_write_arbiter.sv
// Scoreboard bench for distram_write_arbiter: expected grants and reads are queued by the
// stimulus and checked by a negedge monitor.

module tb_distram_write_arbiter;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             flush = 1'b0;
    logic             init_done;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0]    req0_addr = '0, req1_addr = '0;
    logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
    logic             req0_ready, req1_ready;
    logic [AW-1:0]    rd_addr = '0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_chk = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int               id;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wexp_t;

    wexp_t            wq[$];
    logic [WIDTH-1:0] rq[$];

    always #5 clk = ~clk;

    distram_write_arbiter #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .INIT_VALUE ('0)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .init_done  (init_done),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the grant queue on every handshake, the read queue on every read strobe.
    always @(negedge clk) begin
        if (req0_ready || req1_ready) begin
            wexp_t e;
            int    id;
            id = req0_ready ? 0 : 1;
            chk("grant_one_hot", {30'd0, req1_ready, req0_ready}, (id == 0) ? 32'd1 : 32'd2);
            if (wq.size() == 0) begin
                chk("grant_unexpected", 32'(id), 32'hFFFF_FFFF);
            end else begin
                e = wq.pop_front();
                chk("grant_id", 32'(id), 32'(e.id));
                chk("grant_addr", 32'((id == 0) ? req0_addr : req1_addr), 32'(e.addr));
                chk("grant_data", (id == 0) ? req0_data : req1_data, e.data);
            end
        end
        if (rd_chk) begin
            if (rq.size() == 0) begin
                chk("read_unexpected", rd_data, 32'hFFFF_FFFF);
            end else begin
                chk("rd_data", rd_data, rq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("init_done_clear", {31'd0, init_done}, 32'd0);
            chk("ready_clear", {30'd0, req1_ready, req0_ready}, 32'd0);
            chk("rd_masked_clear", rd_data, 32'd0);
            tick();
        end
    endtask

    task automatic expect_run();
        @(negedge clk);
        chk("init_done_run", {31'd0, init_done}, 32'd1);
        tick();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
        rd_addr = a;
        rq.push_back(exp);
        rd_chk = 1'b1;
        tick();
        rd_chk = 1'b0;
    endtask

    // Single write with a same-cycle read of rda.
    task automatic write1(input int id, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                          input logic [AW-1:0] rda, input logic [WIDTH-1:0] rexp);
        wexp_t e;
        e.id = id; e.addr = a; e.data = d;
        wq.push_back(e);
        rq.push_back(rexp);
        if (id == 0) begin
            req0_valid = 1'b1; req0_addr = a; req0_data = d;
        end else begin
            req1_valid = 1'b1; req1_addr = a; req1_data = d;
        end
        rd_addr = rda;
        rd_chk  = 1'b1;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rd_chk     = 1'b0;
    endtask

    // Both requesters valid; expects strict alternation starting with requester 0.
    task automatic both(input int n, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        int   i0 = 0, i1 = 0;
        logic h0, h1;
        wexp_t e;
        for (int i = 0; i < n; i++) begin
            e.id = 0; e.addr = a0 + AW'(i); e.data = d0 + WIDTH'(i); wq.push_back(e);
            e.id = 1; e.addr = a1 + AW'(i); e.data = d1 + WIDTH'(i); wq.push_back(e);
        end
        for (int c = 0; c < 4 * n + 4 && (i0 < n || i1 < n); c++) begin
            req0_valid = (i0 < n); req0_addr = a0 + AW'(i0); req0_data = d0 + WIDTH'(i0);
            req1_valid = (i1 < n); req1_addr = a1 + AW'(i1); req1_data = d1 + WIDTH'(i1);
            @(negedge clk);
            h0 = req0_ready;
            h1 = req1_ready;
            tick();
            if (h0) i0++;
            if (h1) i1++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("both_done", 32'((i0 == n) && (i1 == n)), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] bexp;
        // Reset; requesters held valid during the sweep must not be granted.
        tick();
        #1;
        chk("init_done_reset", {31'd0, init_done}, 32'd0);
        tick();
        resetn = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd1; req1_data = 32'h2;
        rd_addr = 5'd13;
        clear_cycles(32);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        expect_run();
        for (int a = 0; a < DEPTH; a++) do_read(AW'(a), 32'd0);

        // Tie arbitration: requester 0 wins first after reset.
        both(4, 5'd1, 5'd9, 32'hA000_0001, 32'hB000_0009);
        for (int i = 0; i < 4; i++) begin
            do_read(5'd1 + AW'(i), 32'hA000_0001 + WIDTH'(i));
            do_read(5'd9 + AW'(i), 32'hB000_0009 + WIDTH'(i));
        end

        // Single write with same-cycle read of the target.
`ifdef DISTRAM_WRITE_BYPASS_EN
        bexp = 32'hDEAD_BEEF;
`else
        bexp = 32'd0;
`endif
        write1(0, 5'd5, 32'hDEAD_BEEF, 5'd5, bexp);
        do_read(5'd5, 32'hDEAD_BEEF);

        // Flush with simultaneous req1 write: handshake completes, sweep then clears it.
`ifdef DISTRAM_WRITE_BYPASS_EN
        bexp = 32'h0000_1234;
`else
        bexp = 32'd0;
`endif
        flush = 1'b1;
        write1(1, 5'd7, 32'h0000_1234, 5'd7, bexp);
        flush = 1'b0;
        clear_cycles(32);
        expect_run();
        do_read(5'd7, 32'd0);
        do_read(5'd5, 32'd0);

        // Flush re-asserted at sweep cycle 20 restarts the count.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_cycles(20);
        flush = 1'b1;
        clear_cycles(1);
        flush = 1'b0;
        clear_cycles(32);
        expect_run();

        // Reset pulse in RUN: asynchronous drop and full restart.
        write1(0, 5'd2, 32'h5555_AAAA, 5'd0, 32'd0);
        resetn = 1'b0;
        #1;
        chk("init_done_async_reset", {31'd0, init_done}, 32'd0);
        tick();
        resetn = 1'b1;
        clear_cycles(32);
        expect_run();
        do_read(5'd2, 32'd0);
        both(1, 5'd20, 5'd21, 32'hC0, 32'hD0);

        // Forwarding: same address sees new data only with bypass; other address unaffected.
`ifdef DISTRAM_WRITE_BYPASS_EN
        bexp = 32'h0000_00A5;
`else
        bexp = 32'd0;
`endif
        write1(0, 5'd3, 32'h0000_00A5, 5'd3, bexp);
        write1(1, 5'd3, 32'h0000_005A, 5'd4, 32'd0);
        do_read(5'd3, 32'h0000_005A);
        do_read(5'd20, 32'hC0);

        tick();
        chk("grant_queue_drained", 32'(wq.size()), 32'd0);
        chk("read_queue_drained", 32'(rq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/distram_write_arbiter.md
Name: distram_write_arbiter

Overview:
- Owns the single write port of a dual-port distributed RAM (one write/read port A, one combinational read port B) and instantiates that RAM internally.
- Distributed RAM has no reset, so after reset or on a flush request the block first sweeps every entry to INIT_VALUE.
- It then shares the write port between two requesters under round-robin arbitration and exposes port B as a masked combinational read port.
- Used for small per-entry state tables in the out-of-order core (busy/ready tables, rename-side metadata).

Parameters:
- WIDTH, 32, data width of one entry.
- DEPTH, 32, number of entries; must be a power of two, at least 2.
- INIT_VALUE, '0, WIDTH-bit value written to every entry during a sweep.
- ADDR_WIDTH, $clog2(DEPTH), localparam, address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  request a new clear sweep.
- init_done  out  1  high when the sweep is complete and writes are accepted.
- req0_valid  in  1  requester 0 write valid.
- req0_addr  in  ADDR_WIDTH  requester 0 write address.
- req0_data  in  WIDTH  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready: same as requester 0, for requester 1.
- rd_addr  in  ADDR_WIDTH  read address (port B).
- rd_data  out  WIDTH  read data, combinational from rd_addr.

Behaviour:
- FSM states: CLEAR and RUN.
  - resetn low, asynchronously: state=CLEAR, clr_cnt=0, last_grant=1 (so req0 wins the first tie).
- CLEAR:
  - Each cycle the RAM write port is driven with wea=1, addra=clr_cnt, dina=INIT_VALUE, and clr_cnt increments.
  - When clr_cnt==DEPTH-1 is written, next state is RUN and clr_cnt wraps to 0.
  - A sweep takes exactly DEPTH cycles.
  - In this state init_done=0, req0_ready=0, req1_ready=0, rd_data=INIT_VALUE.
- RUN:
  - init_done=1.
  - Grant rule:
    - Only one requester valid: it is granted.
    - Both valid: the requester not equal to last_grant is granted.
    - Neither valid: wea=0.
  - reqN_ready = RUN & grantN. Ready may depend combinationally on valid.
  - A requester must hold addr/data stable while valid is high and ready is low.
  - On a handshake: wea=1, addra/dina come from the granted requester, and last_grant is updated on the clock edge.
- Read timing: rd_data = RAM[rd_addr], combinational. A write accepted in cycle N is visible on rd_data from cycle N+1. A same-cycle read of the written address returns the old value unless the optional feature is compiled in.
- flush:
  - Sampled each cycle. flush=1 in RUN: next state CLEAR with clr_cnt=0. Any write handshaked in that same cycle still completes and is later overwritten by the sweep.
  - flush=1 during CLEAR: clr_cnt restarts at 0, so the sweep is DEPTH cycles measured from the last flush cycle.
- last_grant is not modified by flush.
- Reset deasserted mid-sweep or reset asserted mid-RUN: always a full restart from clr_cnt=0.

Optional Feature:
- DISTRAM_WRITE_BYPASS_EN
  - Defined: in RUN, if a handshake occurs in the same cycle and rd_addr==addra, rd_data=dina (write-first forwarding, still combinational).
  - Undefined: rd_data is always the raw RAM port B output (read-old-data), except the CLEAR masking.

Test Plan:
- Reset release, DEPTH=32: init_done=0 for 32 cycles, then 1; reading every address afterwards returns INIT_VALUE; both readies are 0 during the sweep.
- RUN, req0 writes addr 5 = 0xDEADBEEF: req0_ready=1 in the same cycle; rd_addr=5 returns 0xDEADBEEF next cycle, and old value 0 in the same cycle without bypass.
- Both valid for 4 cycles (req0→addr 1..4, req1→addr 9..12): grants alternate 0,1,0,1 starting with 0 after reset; each stalled requester holds its data; all 8 writes land.
- flush in RUN with a simultaneous req1 write of 0x1234 to addr 7: handshake occurs; init_done drops the next cycle for 32 cycles; addr 7 then reads INIT_VALUE.
- flush reasserted at sweep cycle 20: init_done stays 0 until 32 cycles after that flush; resetn pulsed low in RUN: init_done drops asynchronously and the sweep restarts.
- With DISTRAM_WRITE_BYPASS_EN: write 0xA5 to addr 3 while rd_addr=3 → rd_data=0xA5 in the same cycle; a different rd_addr is unaffected.
